// File: rtl/pwm_peripheral.sv
// pwm_peripheral
//   Turns the SPI register block's enable and duty registers into 16
//   registered output pins. Each pin is driven low, static high, or with a
//   shared 8-bit PWM waveform. All PWM pins share one phase.
//
//   Build option: PWM_GLITCHFREE_UPDATE_EN
//     undefined - the duty compare uses pwm_duty_cycle directly, so a new
//                 duty value is used on the next clk.
//     defined   - the duty compare uses a shadow copy. The copy loads on the
//                 period wrap and once on the first clk after reset release,
//                 so a mid-period write waits for the next period boundary.
//
//   Parameters
//     CLK_DIV    : system clocks per PWM counter step (1..65535)
//     PRESCALE_W : prescaler width, CLK_DIV <= 2**PRESCALE_W
//
//   Ports
//     clk             : system clock, rising edge
//     rst_n           : asynchronous active-low reset
//     en_reg_out_7_0  : output enable, pins 7:0
//     en_reg_out_15_8 : output enable, pins 15:8
//     en_reg_pwm_7_0  : PWM mode select, pins 7:0
//     en_reg_pwm_15_8 : PWM mode select, pins 15:8
//     pwm_duty_cycle  : duty, 0x00 = always low, 0xFF = always high
//     out             : registered output pins
//     period_start    : one-clk pulse on the first clk of each PWM period
module pwm_peripheral #(
    parameter int unsigned CLK_DIV    = 13,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam logic [PRESCALE_W-1:0] PRESCALE_MAX = PRESCALE_W'(CLK_DIV - 1);
    localparam logic [7:0]            CNT_MAX      = 8'd254;

    logic [PRESCALE_W-1:0] prescaler;
    logic [7:0]            pwm_cnt;
    logic [7:0]            duty_active;
    logic                  tick;
    logic                  wrap;
    logic                  pwm_level;
    logic [15:0]           en_out;
    logic [15:0]           en_pwm;
    logic [15:0]           next_out;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    assign tick = (prescaler == PRESCALE_MAX);
    // Edge on which pwm_cnt goes 254 -> 0; period_start shows it one clk later,
    // i.e. on the first clk the counter reads 0.
    assign wrap = tick && (pwm_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else if (wrap) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_start <= 1'b0;
        end else begin
            period_start <= wrap;
        end
    end

`ifdef PWM_GLITCHFREE_UPDATE_EN
    logic loaded;

    // The shadow loads on the same edge that raises period_start, so the new
    // duty governs the period from its very first count (pwm_cnt = 0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_active <= '0;
            loaded      <= 1'b0;
        end else begin
            loaded <= 1'b1;
            if (!loaded || wrap) begin
                duty_active <= pwm_duty_cycle;
            end
        end
    end
`else
    assign duty_active = pwm_duty_cycle;
`endif

    // 0xFF is forced high so a full-duty pin never drops at pwm_cnt = 254.
    assign pwm_level = (duty_active == 8'hFF) ? 1'b1 : (pwm_cnt < duty_active);

    always_comb begin
        next_out = en_out & (~en_pwm | {16{pwm_level}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= next_out;
        end
    end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
- Downstream consumer of the SPI register block.
- Takes the five configuration registers it produces (output enables, PWM enables, duty cycle) and drives 16 output pins.
- Each pin is driven low, static high, or with a shared 8-bit PWM waveform.
- Sits between the SPI register file and the top-level uo_out/uio_out pin mapping.

Parameters:
- CLK_DIV, 13, system clocks per PWM counter step. Legal range 1..65535. Default gives about 3.0 kHz PWM at 10 MHz clk.
- PRESCALE_W, 16, width of the prescaler counter. Must satisfy CLK_DIV <= 2^PRESCALE_W.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en_reg_out_7_0  input  8  output enable, bits 7:0.
- en_reg_out_15_8  input  8  output enable, bits 15:8.
- en_reg_pwm_7_0  input  8  PWM mode select, bits 7:0.
- en_reg_pwm_15_8  input  8  PWM mode select, bits 15:8.
- pwm_duty_cycle  input  8  duty cycle, 0x00 = 0%, 0xFF = 100%.
- out  output  16  registered output pins.
- period_start  output  1  one-clk pulse on the first clk of each PWM period.

Behaviour:
- Reset (async assert, sync-to-clk release):
  - out = 16'h0000, period_start = 0.
  - prescaler = 0, pwm_cnt = 0, duty_active = 0.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - tick = (prescaler == CLK_DIV-1).
  - CLK_DIV=1 gives a tick every clk.
- PWM counter:
  - 8-bit pwm_cnt advances on tick, counting 0..254.
  - On a tick at 254 it wraps to 0, so one period = 255 ticks = 255*CLK_DIV clks.
  - The value 255 is never reached.
- period_start = 1 for exactly one clk, on the clk where pwm_cnt transitions 254 -> 0.
  - No pulse immediately out of reset.
  - First pulse after 255*CLK_DIV clks.
- PWM level:
  - pwm_level = (duty_active == 8'hFF) ? 1 : (pwm_cnt < duty_active).
  - duty 0x00 gives a constant 0.
  - duty 0xFF gives a constant 1, with no one-tick low glitch.
  - duty N (1..254) gives high for N ticks of each 255-tick period.
- Per pin i (0..15):
  - en_out[i] = 0 -> next_out[i] = 0.
  - en_out[i] = 1, en_pwm[i] = 0 -> next_out[i] = 1.
  - en_out[i] = 1, en_pwm[i] = 1 -> next_out[i] = pwm_level.
  - en_pwm is ignored when en_out = 0.
- out is registered from next_out.
  - Latency: enable changes appear on out 1 clk after the input change.
  - PWM edges appear 1 clk after the pwm_cnt change.
- All pins in PWM mode share one phase: identical waveforms, rising edges aligned at pwm_cnt = 0.
- Enable and mode changes take effect immediately (1 clk); they never reset the counters.
- Inputs are quasi-static registers in the same clock domain; no synchronisers.
- Reset mid-period: counters, outputs and duty_active return to 0 asynchronously; the period restarts from 0 after release.

Optional Feature:
- Macro: PWM_GLITCHFREE_UPDATE_EN.
- Defined:
  - duty_active is a shadow register.
  - It loads pwm_duty_cycle only on the clk where period_start is asserted, plus once on the first clk after reset release.
  - Mid-period duty writes take effect at the next period boundary, so no runt pulses occur.
- Undefined:
  - duty_active is combinationally pwm_duty_cycle (no shadow register).
  - Duty changes affect the comparison on the next clk.

Test Plan:
- Reset, all enables 0, duty 0x80 -> out == 0 for 2000 clks; period_start first pulses at clk 255*13 = 3315 after release.
- en_reg_out_7_0=0xFF, en_reg_pwm_7_0=0x00 -> out[7:0]=0xFF exactly 1 clk later; out[15:8]=0.
- en_out=0xFFFF, en_pwm=0x0001, duty 0x40 -> out[0] high 64*13 = 832 clks per 3315-clk period; out[15:1] static high.
- en_out=en_pwm=0xFFFF, duty sweep 0x00 then 0xFF -> out constant 0x0000 for a full period, then constant 0xFFFF for a full period with no low glitch at wrap.
- PWM_GLITCHFREE_UPDATE_EN defined, duty changes 0x20 -> 0xC0 at pwm_cnt = 0x50:
  - Current period high time stays 32 ticks.
  - Next period high time is 192 ticks.
  - Without the macro, out[i] rises again 1 clk after the change.
- Assert rst_n low mid-period with out = 0xFFFF -> out = 0 immediately (async); after release, period_start returns 3315 clks later.
